// File: rtl/ir_decode_alu.sv
// ---------------------------------------------------------------------------
// ir_decode_alu
//
// Instruction register, MIPS-style decoder and ALU for a single-cycle
// datapath. The instruction register is the only state; everything else
// (field extraction, control decode, immediate extension, ALU result and
// zero flag) is combinational from inst, rs_data and rt_data. The decoded
// result therefore changes in the same cycle that inst changes, with no
// added latency.
//
// Load protocol: ir_en is a one-cycle load strobe sampled on the rising
// clock edge. The register can always accept a load. The outputs carry no
// handshake of their own. They always reflect the current inst.
//
// Optional feature (macro ALU_SHIFT_EN):
//   When this macro is defined, R-type funct 0x00 decodes as SLL and funct
//   0x02 decodes as SRL. Both shift rt_data logically by inst[10:6]. The
//   all-zero word stays a NOP.
//   When the macro is undefined, those functs decode as NOP. The shift
//   ALU codes are then never produced.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset (clears inst)
//   ir_en      in   1   instruction register load enable
//   inst_in    in  32   fetched instruction word
//   rs_data    in  32   register-file read data for rs (ALU operand A)
//   rt_data    in  32   register-file read data for rt
//   inst       out 32   instruction register contents
//   rs/rt/rd   out  5   inst[25:21] / inst[20:16] / inst[15:11]
//   imm16      out 16   inst[15:0]
//   imm26      out 26   inst[25:0]
//   alu_ctr    out  4   ALU operation code
//   reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump
//              out  1   decoder controls
//   alu_out    out 32   ALU result
//   zf         out  1   set when alu_out == 0
// ---------------------------------------------------------------------------
module ir_decode_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_en,
  input  logic [31:0] inst_in,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] inst,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output logic [3:0]  alu_ctr,
  output logic        reg_dst,
  output logic        reg_wrt,
  output logic        mem_read,
  output logic        mem_wrt,
  output logic        mem_reg,
  output logic        alu_src,
  output logic        branch,
  output logic        jump,
  output logic [31:0] alu_out,
  output logic        zf
);

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_LUI = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zext_imm;   // andi/ori take a zero-extended immediate
  logic        rtype_hit;  // funct recognised inside an R-type word
  logic        mem_read_d;
  logic        mem_wrt_d;
  logic [31:0] imm_ext;
  logic [31:0] op_b;

  // -------------------------------------------------------------------------
  // Instruction register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst <= 32'h0000_0000;
    end else if (ir_en) begin
      inst <= inst_in;
    end
  end

  // -------------------------------------------------------------------------
  // Field extraction
  // -------------------------------------------------------------------------
  assign opcode = inst[31:26];
  assign funct  = inst[5:0];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign imm16  = inst[15:0];
  assign imm26  = inst[25:0];

  // -------------------------------------------------------------------------
  // Control decode. Every output starts at its NOP value. An unrecognised
  // opcode or funct therefore falls through to all-zero controls with ADD.
  // -------------------------------------------------------------------------
  always_comb begin
    alu_ctr    = ALU_ADD;
    reg_dst    = 1'b0;
    reg_wrt    = 1'b0;
    mem_read_d = 1'b0;
    mem_wrt_d  = 1'b0;
    mem_reg    = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    zext_imm   = 1'b0;
    rtype_hit  = 1'b0;

    // The all-zero word looks like "sll $0,$0,0" and must stay a NOP
    // even when shifts are enabled.
    if (inst != 32'h0000_0000) begin
      case (opcode)
        OP_RTYPE: begin
          rtype_hit = 1'b1;
          case (funct)
            FN_ADD:  alu_ctr = ALU_ADD;
            FN_SUB:  alu_ctr = ALU_SUB;
            FN_AND:  alu_ctr = ALU_AND;
            FN_OR:   alu_ctr = ALU_OR;
            FN_XOR:  alu_ctr = ALU_XOR;
            FN_NOR:  alu_ctr = ALU_NOR;
            FN_SLT:  alu_ctr = ALU_SLT;
`ifdef ALU_SHIFT_EN
            FN_SLL:  alu_ctr = ALU_SLL;
            FN_SRL:  alu_ctr = ALU_SRL;
`endif
            default: begin
              rtype_hit = 1'b0;
              alu_ctr   = ALU_ADD;
            end
          endcase
          if (rtype_hit) begin
            reg_dst = 1'b1;
            reg_wrt = 1'b1;
          end
        end
        OP_ADDI: begin
          alu_ctr = ALU_ADD;
          reg_wrt = 1'b1;
          alu_src = 1'b1;
        end
        OP_SLTI: begin
          alu_ctr = ALU_SLT;
          reg_wrt = 1'b1;
          alu_src = 1'b1;
        end
        OP_ANDI: begin
          alu_ctr  = ALU_AND;
          reg_wrt  = 1'b1;
          alu_src  = 1'b1;
          zext_imm = 1'b1;
        end
        OP_ORI: begin
          alu_ctr  = ALU_OR;
          reg_wrt  = 1'b1;
          alu_src  = 1'b1;
          zext_imm = 1'b1;
        end
        OP_LUI: begin
          alu_ctr = ALU_LUI;
          reg_wrt = 1'b1;
          alu_src = 1'b1;
        end
        OP_LW: begin
          alu_ctr    = ALU_ADD;
          alu_src    = 1'b1;
          mem_read_d = 1'b1;
          mem_reg    = 1'b1;
          reg_wrt    = 1'b1;
        end
        OP_SW: begin
          alu_ctr   = ALU_ADD;
          alu_src   = 1'b1;
          mem_wrt_d = 1'b1;
        end
        OP_BEQ: begin
          alu_ctr = ALU_SUB;
          branch  = 1'b1;
        end
        OP_J: begin
          alu_ctr = ALU_ADD;
          jump    = 1'b1;
        end
        default: begin
          alu_ctr = ALU_ADD;
        end
      endcase
    end
  end

  // The decode above never sets both memory strobes. The gating makes
  // the exclusion structural, so it cannot be broken by a later table edit.
  assign mem_read = mem_read_d;
  assign mem_wrt  = mem_wrt_d & ~mem_read_d;

  // -------------------------------------------------------------------------
  // Operand selection
  // -------------------------------------------------------------------------
  assign imm_ext = zext_imm ? {16'h0000, inst[15:0]}
                            : {{16{inst[15]}}, inst[15:0]};
  assign op_b    = alu_src ? imm_ext : rt_data;

  // -------------------------------------------------------------------------
  // ALU. ADD/SUB wrap modulo 2^32 and raise no overflow indication.
  // -------------------------------------------------------------------------
  always_comb begin
    alu_out = 32'h0000_0000;
    case (alu_ctr)
      ALU_AND: alu_out = rs_data & op_b;
      ALU_OR:  alu_out = rs_data | op_b;
      ALU_ADD: alu_out = rs_data + op_b;
      ALU_XOR: alu_out = rs_data ^ op_b;
      ALU_SUB: alu_out = rs_data - op_b;
      ALU_SLT: alu_out = {31'h0, ($signed(rs_data) < $signed(op_b))};
      ALU_LUI: alu_out = {inst[15:0], 16'h0000};
      ALU_NOR: alu_out = ~(rs_data | op_b);
`ifdef ALU_SHIFT_EN
      // Shifts act on rt_data. op_b equals rt_data here because R-type
      // words leave alu_src low.
      ALU_SLL: alu_out = op_b << inst[10:6];
      ALU_SRL: alu_out = op_b >> inst[10:6];
`endif
      default: alu_out = 32'h0000_0000;
    endcase
  end

  assign zf = (alu_out == 32'h0000_0000);

endmodule

// File: tb/tb_ir_decode_alu.sv
// ---------------------------------------------------------------------------
// tb_ir_decode_alu
//
// Scoreboard bench for ir_decode_alu. The driver applies one instruction per
// cycle. It then pushes the reference model's view of every output onto
// exp_q. A separate monitor on the falling edge pops one entry and compares
// it whenever an entry is pending.
//
// The reference model decodes each instruction by mnemonic and computes the
// result with plain arithmetic. Define ALU_SHIFT_EN for both the bench and
// the RTL to cover the shift build.
// ---------------------------------------------------------------------------
module tb_ir_decode_alu;

  typedef struct packed {
    logic [31:0] inst;
    logic [3:0]  alu_ctr;
    logic [7:0]  ctl;  // {reg_dst,reg_wrt,mem_read,mem_wrt,mem_reg,alu_src,branch,jump}
    logic [31:0] alu_out;
    logic        zf;
  } exp_t;

  localparam int W = $bits(exp_t);

  logic        clk;
  logic        rst_n;
  logic        ir_en;
  logic [31:0] inst_in;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] inst;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [3:0]  alu_ctr;
  logic        reg_dst;
  logic        reg_wrt;
  logic        mem_read;
  logic        mem_wrt;
  logic        mem_reg;
  logic        alu_src;
  logic        branch;
  logic        jump;
  logic [31:0] alu_out;
  logic        zf;

  logic [W-1:0] exp_q[$];
  logic [31:0]  model_ir;
  int           n_tests;
  int           n_fail;

  ir_decode_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir_en    (ir_en),
    .inst_in  (inst_in),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .inst     (inst),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .imm16    (imm16),
    .imm26    (imm26),
    .alu_ctr  (alu_ctr),
    .reg_dst  (reg_dst),
    .reg_wrt  (reg_wrt),
    .mem_read (mem_read),
    .mem_wrt  (mem_wrt),
    .mem_reg  (mem_reg),
    .alu_src  (alu_src),
    .branch   (branch),
    .jump     (jump),
    .alu_out  (alu_out),
    .zf       (zf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] simm;
    logic [31:0] zimm;
    logic [31:0] res;
    logic [3:0]  code;
    logic [7:0]  ctl;
    op   = ir[31:26];
    fn   = ir[5:0];
    simm = {{16{ir[15]}}, ir[15:0]};
    zimm = {16'h0000, ir[15:0]};
    code = 4'b0010;       // NOP: ADD of the raw register operands
    ctl  = 8'b0000_0000;
    res  = a + b;
    if (ir != 32'h0) begin
      case (op)
        6'h00: begin
          case (fn)
            6'h20: begin ctl = 8'b1100_0000; code = 4'b0010; res = a + b; end
            6'h22: begin ctl = 8'b1100_0000; code = 4'b0110; res = a - b; end
            6'h24: begin ctl = 8'b1100_0000; code = 4'b0000; res = a & b; end
            6'h25: begin ctl = 8'b1100_0000; code = 4'b0001; res = a | b; end
            6'h26: begin ctl = 8'b1100_0000; code = 4'b0011; res = a ^ b; end
            6'h27: begin ctl = 8'b1100_0000; code = 4'b1100; res = ~(a | b); end
            6'h2A: begin
              ctl = 8'b1100_0000; code = 4'b0111;
              res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end
`ifdef ALU_SHIFT_EN
            6'h00: begin ctl = 8'b1100_0000; code = 4'b1000; res = b << ir[10:6]; end
            6'h02: begin ctl = 8'b1100_0000; code = 4'b1001; res = b >> ir[10:6]; end
`endif
            default: ;
          endcase
        end
        6'h08: begin ctl = 8'b0100_0100; res = a + simm; end
        6'h0A: begin
          ctl = 8'b0100_0100; code = 4'b0111;
          res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
        end
        6'h0C: begin ctl = 8'b0100_0100; code = 4'b0000; res = a & zimm; end
        6'h0D: begin ctl = 8'b0100_0100; code = 4'b0001; res = a | zimm; end
        6'h0F: begin ctl = 8'b0100_0100; code = 4'b1010; res = {ir[15:0], 16'h0000}; end
        6'h23: begin ctl = 8'b0110_1100; res = a + simm; end
        6'h2B: begin ctl = 8'b0001_0100; res = a + simm; end
        6'h04: begin ctl = 8'b0000_0010; code = 4'b0110; res = a - b; end
        6'h02: begin ctl = 8'b0000_0001; res = a + b; end
        default: ;
      endcase
    end
    e.inst    = ir;
    e.alu_ctr = code;
    e.ctl     = ctl;
    e.alu_out = res;
    e.zf      = (res == 32'h0);
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the falling edge. The expectation is
  // pushed just after the rising edge, so the monitor checks it at the next
  // falling edge while the same inputs are still applied.
  task automatic drive(input logic en, input logic [31:0] w,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    #1;
    ir_en   = en;
    inst_in = w;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    if (en && rst_n) model_ir = w;
    exp_q.push_back(W'(model(model_ir, rs_data, rt_data)));
  endtask

  // Assert reset between edges with a load pending. The register must
  // clear immediately and stay clear across a rising edge.
  task automatic mid_reset();
    @(negedge clk);
    @(posedge clk);
    #2;
    ir_en   = 1'b1;
    inst_in = 32'h0085_1020;
    rst_n   = 1'b0;
    model_ir = 32'h0;
    #1;
    exp_q.push_back(W'(model(model_ir, rs_data, rt_data)));
    @(posedge clk);
    #1;
    exp_q.push_back(W'(model(model_ir, rs_data, rt_data)));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    ir_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0]  ops[13];
    logic [5:0]  fns[10];
    logic [31:0] w;
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F,
            6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h3F};
    w = $urandom();
    w[31:26] = ops[$urandom_range(0, 12)];
    if ($urandom_range(0, 7) == 0) w[31:26] = 6'($urandom());
    if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 9)];
    return w;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_t'(exp_q.pop_front());
      chk("inst",    inst, e.inst);
      chk("rs",      {27'h0, rs}, {27'h0, e.inst[25:21]});
      chk("rt",      {27'h0, rt}, {27'h0, e.inst[20:16]});
      chk("rd",      {27'h0, rd}, {27'h0, e.inst[15:11]});
      chk("imm16",   {16'h0, imm16}, {16'h0, e.inst[15:0]});
      chk("imm26",   {6'h0, imm26}, {6'h0, e.inst[25:0]});
      chk("alu_ctr", {28'h0, alu_ctr}, {28'h0, e.alu_ctr});
      chk("controls", {24'h0, reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg,
                       alu_src, branch, jump}, {24'h0, e.ctl});
      chk("alu_out", alu_out, e.alu_out);
      chk("zf",      {31'h0, zf}, {31'h0, e.zf});
      chk("mem_excl", {31'h0, mem_read & mem_wrt}, 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    n_tests  = 0;
    n_fail   = 0;
    model_ir = 32'h0;
    rst_n    = 1'b0;
    ir_en    = 1'b0;
    inst_in  = 32'h0;
    rs_data  = 32'h0;
    rt_data  = 32'h0;

    // Reset state: a load is requested but reset is held.
    drive(1'b1, 32'h0085_1020, 32'd3, 32'd4);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases
    drive(1'b1, 32'h0085_1020, 32'd5, 32'd7);               // add -> 12
    drive(1'b1, 32'h1085_0003, 32'h1234, 32'h1234);         // beq equal
    drive(1'b0, 32'hDEAD_BEEF, 32'h1234, 32'h1235);         // hold, beq unequal
    drive(1'b1, 32'h8C82_FFFC, 32'h100, 32'h55);            // lw sign-extend
    drive(1'b1, 32'h3482_FFFC, 32'h0, 32'h0);               // ori zero-extend
    drive(1'b1, 32'h2082_FFFF, 32'h0, 32'h9);               // addi -> all ones
    drive(1'b1, 32'h0085_1020, 32'h7FFF_FFFF, 32'h1);       // add wrap
    drive(1'b1, 32'h0085_1022, 32'h0, 32'h1);               // sub wrap
    drive(1'b1, 32'h0085_102A, 32'hFFFF_FFFF, 32'h1);       // slt signed
    drive(1'b1, 32'h2882_8000, 32'h0, 32'h0);               // slti negative imm
    drive(1'b1, 32'h3082_8001, 32'hFFFF_FFFF, 32'h0);       // andi zero-extend
    drive(1'b1, 32'h3C02_ABCD, 32'h1, 32'h2);               // lui
    drive(1'b1, 32'hAC82_0010, 32'h40, 32'h3);              // sw
    drive(1'b1, 32'h0800_0040, 32'h1, 32'h1);               // j
    drive(1'b1, 32'h0005_1100, 32'h0, 32'h1);               // sll 4 / NOP
    drive(1'b1, 32'h0005_1102, 32'h0, 32'h80);              // srl 4 / NOP
    drive(1'b1, 32'h0000_0000, 32'h6, 32'h7);               // all-zero NOP
    drive(1'b1, 32'h0085_103F, 32'h6, 32'h7);               // undefined funct
    drive(1'b1, 32'hFC85_1020, 32'h6, 32'h7);               // undefined opcode

    mid_reset();
    drive(1'b1, 32'h0085_1024, 32'hF0F0, 32'hFF00);         // first load after reset

    // Randomized
    for (int i = 0; i < 400; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
      drive(($urandom_range(0, 7) != 0), rand_inst(), a, b);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_decode_alu.md
IR_DECODE_ALU -- requirements
Module: ir_decode_alu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports: clk, rst_n.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 ir_en  in  1  instruction register load enable.
REQ-005 inst_in  in  32  fetched instruction word.
REQ-006 rs_data  in  32  register-file read data for rs.
REQ-007 rt_data  in  32  register-file read data for rt.
REQ-008 inst  out  32  instruction register contents.
REQ-009 rs, rt, rd  out  5 each  = inst[25:21], inst[20:16], inst[15:11].
REQ-010 imm16  out  16, imm26  out  26  = inst[15:0], inst[25:0].
REQ-011 alu_ctr  out  4  ALU operation code.
REQ-012 reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump  out  1 each  decoder controls.
REQ-013 alu_out  out  32  ALU result; zf  out  1  set when alu_out == 0.

Function
REQ-014 On a rising clk edge with ir_en=1, inst SHALL load inst_in; with ir_en=0, inst SHALL hold.
REQ-015 Decoder and ALU SHALL be combinational from inst, rs_data and rt_data; results valid in the same cycle inst updates; zero added latency.
REQ-016 alu_ctr codes SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, LUI 1010, NOR 1100.
REQ-017 ALU operand A SHALL be rs_data; operand B SHALL be rt_data when alu_src=0, else the extended imm16.
REQ-018 imm16 SHALL be zero-extended for andi/ori and sign-extended for all other immediate ops.
REQ-019 ADD/SUB SHALL wrap modulo 2^32 with no overflow flag or trap.
REQ-020 SLT SHALL be a signed compare, result 32'd1 or 32'd0.
REQ-021 LUI SHALL yield {imm16, 16'h0000}.
REQ-022 R-type (opcode 000000) SHALL decode funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT; reg_dst=1, reg_wrt=1, alu_src=0, other controls 0.
REQ-023 I-type: addi 0x08 ADD, slti 0x0A SLT, andi 0x0C AND, ori 0x0D OR, lui 0x0F LUI; reg_wrt=1, alu_src=1, reg_dst=0.
REQ-024 lw 0x23: ADD, alu_src=1, mem_read=1, mem_reg=1, reg_wrt=1.
REQ-025 sw 0x2B: ADD, alu_src=1, mem_wrt=1, reg_wrt=0.
REQ-026 beq 0x04: SUB, alu_src=0, branch=1, no writes; zf gives the branch condition.
REQ-027 j 0x02: jump=1, all other controls 0, alu_ctr ADD.
REQ-028 inst == 0 and any undefined opcode/funct SHALL be a NOP: all control outputs 0, alu_ctr ADD.
REQ-029 mem_read and mem_wrt SHALL never be asserted together.

Reset
REQ-030 rst_n low SHALL immediately clear inst to 0 regardless of clk or ir_en, producing NOP controls, independent of the ALU_SHIFT_EN setting.
REQ-031 Reset SHALL be released synchronously to operation: the first load occurs on the first rising clk edge with rst_n high and ir_en=1.

Configuration
REQ-032 Macro ALU_SHIFT_EN: when defined, R-type funct 0x00 SHALL decode as SLL and 0x02 as SRL, shifting rt_data by inst[10:6] (logical), reg_dst=1, reg_wrt=1, except that inst == 0 SHALL remain a NOP.
REQ-033 Without ALU_SHIFT_EN, funct 0x00/0x02 SHALL decode as NOP and codes 1000/1001 SHALL never be emitted.

Verification
REQ-034 Reset: rst_n=0 mid-cycle -> inst=0, all controls 0, alu_ctr=0010 immediately.
REQ-035 add: inst_in=0x00851020, ir_en=1, rs_data=5, rt_data=7 -> after edge, alu_out=12, reg_dst=1, reg_wrt=1, rd=2.
REQ-036 beq equal: inst_in=0x10850003, rs_data=rt_data=0x1234 -> alu_ctr=0110, zf=1, branch=1; with rt_data=0x1235 -> zf=0.
REQ-037 lw/sign-extend: inst_in=0x8C82FFFC, rs_data=0x100 -> alu_out=0xFC, mem_read=1, mem_reg=1, alu_src=1; ori inst_in=0x3482FFFC, rs_data=0 -> alu_out=0x0000FFFC.
REQ-038 Hold and wrap: ir_en=0 with new inst_in -> inst unchanged; addi 0x2082FFFF with rs_data=0 -> alu_out=0xFFFFFFFF; add 0x7FFFFFFF+1 -> 0x80000000.
REQ-039 Shift (ALU_SHIFT_EN defined): inst_in=0x00051100, rt_data=1 -> alu_out=0x10, alu_ctr=1000; undefined -> NOP controls.
